// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS front end.
package mips_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0000;

  // IDLE: nothing outstanding; BUSY: live request; DROP: stale request draining.
  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DROP
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // Force a byte address onto a word boundary.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of {inst, pc} entries. Clear beats push and pop.
module fetch_queue
  import mips_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  fetch_entry_t             push_entry,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t    mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;

  // Entry storage write port.
  // NOTE: storage has no reset; only count says which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the fetch PC, runs the imem req/ack handshake and feeds
// the datapath from a small prefetch queue. Redirects flush and restart fetch.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              QDEPTH   = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic [XLEN-1:0] inst_pc4,
  input  logic            inst_ready,
  output logic            fetch_err
);

  localparam int CW = $clog2(QDEPTH) + 1;

  fetch_state_t    state, state_next;
  logic [XLEN-1:0] fetch_pc, fetch_pc_next, addr_next;
  logic            err_next;
  logic            push, pop;
  logic [CW-1:0]   count;
  logic [CW:0]     occ_after;
  fetch_entry_t    head, push_entry;

  assign inst_valid = (count != '0);
  assign pop        = inst_valid && inst_ready;
  assign push_entry = '{inst: imem_rdata, pc: fetch_pc};
  // Occupancy once this cycle's push and pop have landed; decides back-to-back issue.
  assign occ_after  = {1'b0, count} + (CW+1)'(1) - (CW+1)'(pop);

  fetch_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk        (clk),
    .rst        (rst),
    .clear      (redirect_valid),
    .push       (push),
    .pop        (pop),
    .push_entry (push_entry),
    .head       (head),
    .count      (count)
  );

  // Next-state, next fetch PC, next request address and error flag.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    addr_next     = imem_addr;
    err_next      = fetch_err;
    push          = 1'b0;
    if (redirect_valid) begin
      // Redirect wins: any in-flight data is stale, and an unacked request
      // must still be held until memory answers it.
      fetch_pc_next = word_align(redirect_pc);
      if (redirect_pc[1:0] != 2'b00) err_next = 1'b1;
      unique case (state)
        IDLE:    state_next = IDLE;
        BUSY,
        DROP:    state_next = imem_ack ? IDLE : DROP;
        default: state_next = IDLE;
      endcase
    end else begin
      unique case (state)
        IDLE: begin
          if (count < CW'(QDEPTH)) begin
            state_next = BUSY;
            addr_next  = fetch_pc;
          end
        end
        BUSY: begin
          if (imem_ack) begin
            push          = 1'b1;
            fetch_pc_next = fetch_pc + XLEN'(4);
            if (occ_after < (CW+1)'(QDEPTH)) addr_next = fetch_pc + XLEN'(4);
            else                             state_next = IDLE;
          end
        end
        DROP: begin
          if (imem_ack) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // State, fetch PC, registered request outputs and sticky error flag.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      fetch_err <= 1'b0;
    end else begin
      state     <= state_next;
      fetch_pc  <= fetch_pc_next;
      imem_req  <= (state_next != IDLE);
      imem_addr <= addr_next;
      fetch_err <= err_next;
    end
  end

  // Head outputs; an empty queue presents a nop at PC 0.
  assign inst     = inst_valid ? head.inst : INST_NOP;
  assign inst_pc  = inst_valid ? head.pc   : '0;
  assign inst_pc4 = inst_pc + XLEN'(4);

endmodule
